// File: rtl/tag_reorder_buffer_pkg.sv
// Shared sizing constants for the per-port tag reorder buffer.
// TAG_BITS derivation lives here so other read-path blocks size tags the same way.
package tag_reorder_buffer_pkg;

  localparam int DEFAULT_WIDTH = 64;
  localparam int DEFAULT_DEPTH = 32;

  // floor(log2(depth-1)) + 1; equals log2(depth) for power-of-two depths >= 2
  function automatic int tag_bits_for(input int depth);
    int v;
    int n;
    v = depth - 1;
    n = 0;
    while (v > 1) begin
      v = v >> 1;
      n = n + 1;
    end
    return n + 1;
  endfunction

  localparam int DEFAULT_TAG_BITS = tag_bits_for(DEFAULT_DEPTH);

endpackage

// File: rtl/tag_reorder_buffer_if.sv
// Port-side bundle of the reorder buffer: tag allocation, tagged returns and the ordered output.
// slave is the buffer's view; master is the issuing port / crossbar / consumer side.
interface tag_reorder_buffer_if
  import tag_reorder_buffer_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int TAG_BITS = DEFAULT_TAG_BITS
);

  logic                      alloc;
  logic [TAG_BITS-1:0]       alloc_tag;
  logic                      full;
  logic                      ret_en;
  logic [TAG_BITS-1:0]       ret_tag;
  logic [WIDTH-1:0]          ret_data;
  logic [WIDTH+TAG_BITS-1:0] q;
  logic                      valid;
  logic                      stall;

  modport master (
    output alloc, ret_en, ret_tag, ret_data, stall,
    input  alloc_tag, full, q, valid
  );

  modport slave (
    input  alloc, ret_en, ret_tag, ret_data, stall,
    output alloc_tag, full, q, valid
  );

endinterface

// File: rtl/tag_reorder_buffer_storage.sv
// Per-tag data register file with a present bit per entry.
// One write port (returning data), a combinational read at head, and a present lookup for returns.
module tag_reorder_buffer_storage #(
  parameter int WIDTH    = 64,
  parameter int DEPTH    = 32,
  parameter int TAG_BITS = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [TAG_BITS-1:0] wr_tag,
  input  logic [WIDTH-1:0]    wr_data,
  input  logic                clr_en,
  input  logic [TAG_BITS-1:0] rd_tag,
  output logic [WIDTH-1:0]    rd_data,
  output logic                rd_present,
  input  logic [TAG_BITS-1:0] chk_tag,
  output logic                chk_present
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] present;

  // Data words need no reset: present gates every use of them.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_tag] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      present <= '0;
    end else begin
      if (clr_en) begin
        present[rd_tag] <= 1'b0;
      end
      if (wr_en) begin
        present[wr_tag] <= 1'b1;
      end
    end
  end

  assign rd_data     = mem[rd_tag];
  assign rd_present  = present[rd_tag];
  assign chk_present = present[chk_tag];

endmodule

// File: rtl/tag_reorder_buffer.sv
// In-order return stage: hands out sequential read tags, absorbs out-of-order tagged returns,
// and releases data in allocation order. Optional macro TAG_REORDER_BUFFER_BYPASS_EN adds a head bypass.
module tag_reorder_buffer
  import tag_reorder_buffer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input logic                 clk,
  input logic                 rst,
  tag_reorder_buffer_if.slave bus
);

  localparam int TAG_BITS = tag_bits_for(DEPTH);
  localparam int CNT_BITS = TAG_BITS + 1;

  logic [TAG_BITS-1:0]       head;
  logic [TAG_BITS-1:0]       tail;
  logic [CNT_BITS-1:0]       count;
  logic [WIDTH+TAG_BITS-1:0] q_r;
  logic                      valid_r;

  logic                      full_w;
  logic                      alloc_ok;
  logic [TAG_BITS-1:0]       ret_off;
  logic                      ret_outstanding;
  logic                      ret_present;
  logic                      ret_ok;
  logic                      head_present;
  logic [WIDTH-1:0]          head_data;
  logic                      out_ready;
  logic                      pop_stored;
  logic                      bypass;
  logic                      advance;
  logic                      wr_en;
  logic [WIDTH-1:0]          out_data;

  assign full_w   = (count == CNT_BITS'(DEPTH));
  assign alloc_ok = bus.alloc && !full_w;

  // A tag is outstanding when its distance from head (mod DEPTH) is below count;
  // count disambiguates the empty and full cases where head == tail.
  assign ret_off         = bus.ret_tag - head;
  assign ret_outstanding = ({1'b0, ret_off} < count);
  assign ret_ok          = bus.ret_en && ret_outstanding && !ret_present;

  // Output handshake: q/valid is a register; an entry transfers on every edge where
  // valid && !stall. With stall high q and valid hold; a new entry loads only when
  // the register is empty or being drained this edge.
  assign out_ready  = !valid_r || !bus.stall;
  assign pop_stored = head_present && out_ready;

`ifdef TAG_REORDER_BUFFER_BYPASS_EN
  // ret_ok already implies the head entry is outstanding and not yet present.
  assign bypass = ret_ok && (bus.ret_tag == head) && out_ready;
`else
  assign bypass = 1'b0;
`endif

  assign advance  = pop_stored || bypass;
  assign wr_en    = ret_ok && !bypass;
  assign out_data = bypass ? bus.ret_data : head_data;

  tag_reorder_buffer_storage #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .TAG_BITS (TAG_BITS)
  ) u_storage (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_tag      (bus.ret_tag),
    .wr_data     (bus.ret_data),
    .clr_en      (pop_stored),
    .rd_tag      (head),
    .rd_data     (head_data),
    .rd_present  (head_present),
    .chk_tag     (bus.ret_tag),
    .chk_present (ret_present)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (alloc_ok) begin
        tail <= tail + 1'b1;
      end
      if (advance) begin
        head <= head + 1'b1;
      end
      count <= count + CNT_BITS'(alloc_ok) - CNT_BITS'(advance);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_r     <= '0;
      valid_r <= 1'b0;
    end else if (advance) begin
      q_r     <= {out_data, head};
      valid_r <= 1'b1;
    end else if (valid_r && !bus.stall) begin
      valid_r <= 1'b0;
    end
  end

  assign bus.alloc_tag = tail;
  assign bus.full      = full_w;
  assign bus.q         = q_r;
  assign bus.valid     = valid_r;

endmodule

// File: doc/tag_reorder_buffer.md
Name: tag_reorder_buffer

Overview:
- Per-port in-order return stage on the scratch-pad read path.
- Hands out sequential read tags when a port issues a read, and accepts tagged data returning out of order from the receive crossbar.
- Releases data strictly in tag-allocation order through a valid/stall output register.
- One instance per port; sits between the receive crossbar output and the port's q/valid.

Parameters:
- WIDTH, 64, data bits per returned word.
- DEPTH, 32, outstanding reads per port; power of two, minimum 2.
- TAG_BITS, log2(DEPTH-1)+1, tag width (5 at default).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- alloc  input  1  read issued this cycle; consumes alloc_tag.
- alloc_tag  output  TAG_BITS  tag to attach to the read; combinational from tail pointer.
- full  output  1  no free tag; combinational; (count == DEPTH).
- ret_en  input  1  tagged data returning this cycle.
- ret_tag  input  TAG_BITS  tag of the returning data.
- ret_data  input  WIDTH  returning read data.
- q  output  WIDTH+TAG_BITS  {data, tag}; tag in [TAG_BITS-1:0], data above it.
- valid  output  1  q holds an in-order result.
- stall  input  1  consumer cannot accept q this cycle.

Behaviour:
- State:
  - head and tail pointers (TAG_BITS, wrap modulo DEPTH).
  - count (TAG_BITS+1).
  - present[DEPTH] bit vector and DEPTH x WIDTH storage.
  - Output register {q, valid}.
- Reset (rst sampled high): head=tail=count=0, present all 0, valid=0, q=0.
  - Reset mid-operation discards all outstanding tags; returns arriving in later cycles carry stale tags and are ignored because their present/outstanding check fails.
- Allocate: alloc && !full at an edge -> tail+1, count+1. alloc && full -> ignored, no state change.
- Return: ret_en at an edge -> storage[ret_tag]=ret_data, present[ret_tag]=1.
  - A return is ignored if ret_tag is not outstanding, i.e. not in [head, tail) modulo DEPTH with count accounted for.
  - A return is also ignored if present[ret_tag] is already 1.
- Pop condition (cycle-evaluated): present[head] && (!valid || !stall).
  - On the edge where it holds: q <= {storage[head], head}, valid <= 1, present[head] <= 0, head+1, count-1.
- Output handshake:
  - valid && !stall at an edge, with no pop -> valid <= 0.
  - valid && stall -> q and valid held unchanged.
- Count and full:
  - alloc and pop on the same edge -> count unchanged.
  - full may deassert in the cycle after a pop.
  - The entry in the output register no longer occupies a tag.
- Base latency: ret_en at edge E0 for the head tag -> pop at E1 -> valid high after E1 (2 edges).
- Wrap: tag DEPTH-1 is followed by tag 0; pointer compare uses count to separate the empty and full cases.

Optional Feature:
- Macro: TAG_REORDER_BUFFER_BYPASS_EN.
- Defined:
  - When ret_en && ret_tag==head && present[head]==0 && (!valid || !stall), ret_data loads directly into q at the same edge.
  - present is not set; head and count advance.
  - Latency is 1 edge.
- Undefined:
  - The return always goes through storage; 2-edge minimum latency.
- Ordering and all other behaviour are identical either way.

Decomposition:
- Shared include (alongside log2.vh): TAG_BITS derivation and default DEPTH/WIDTH constants, also used by scratch_pad for REORDER_BITS.
- One natural sub-module: tag_reorder_storage.
  - DEPTH x WIDTH register file with one write port (ret_tag/ret_data) and a combinational read at head.
  - Holds the present vector with set-on-write and clear-on-pop.

Test Plan:
- In-order: 4 allocs (tags 0..3), returns 0,1,2,3 one per cycle, stall=0 -> valid for 4 consecutive cycles, q tags 0,1,2,3 with matching data; first valid 2 edges after the ret_en for tag 0 (1 edge with bypass).
- Out-of-order: allocate 0..3, return order 3,1,0,2 with data 0x33,0x11,0x00,0x22 -> output 0x00,0x11,0x22,0x33; nothing valid before tag 0 returns.
- Full/wrap: 32 allocs -> full=1 and alloc_tag=0; a 33rd alloc is ignored. Return and drain tag 0 -> full=0 the cycle after the pop; next alloc gets tag 0. Repeat across 3 wraps.
- Stall: valid with stall=1 for 5 cycles while tags 1,2 are present -> q frozen on tag 0. Release -> tags 1,2 follow on consecutive cycles.
- Illegal returns: return tag 7 with only tags 0..2 outstanding, and a duplicate return of tag 1 -> both ignored; output sequence and count unchanged.
- Reset mid-flight: 5 outstanding, 2 present, rst for 1 cycle -> valid=0, full=0, alloc_tag=0. A late return with tag 3 after reset -> ignored.
